// File: rtl/multi_axis_angle_ctrl.sv
// rtl/multi_axis_angle_ctrl.sv - multi-axis angle-to-rate outer loop with one shared multiplier
// Runs ERR/SCALE/LIMIT per axis from a latched input snapshot; outputs commit atomically in DONE.
module multi_axis_angle_ctrl #(
  parameter int NUM_AXES  = 3,
  parameter int REC_W     = 8,
  parameter int RATE_W    = 16,
  parameter int TGT_SHIFT = 2,
  parameter int CENTER    = 500,
  parameter int SCALE_W   = 16,
  parameter int SHIFT_W   = 5
) (
  input  logic                         us_clk,
  input  logic                         resetn,
  input  logic                         start_signal,
  input  logic [NUM_AXES*REC_W-1:0]    target_flat,
  input  logic [NUM_AXES*RATE_W-1:0]   actual_flat,
  input  logic [NUM_AXES-1:0]          actual_add,
  input  logic [NUM_AXES*SCALE_W-1:0]  scale_mult_flat,
  input  logic [NUM_AXES*SHIFT_W-1:0]  scale_shift_flat,
  input  logic [NUM_AXES*RATE_W-1:0]   rate_limit_flat,
  input  logic [RATE_W-1:0]            slew_limit,
  output logic [NUM_AXES*RATE_W-1:0]   rate_out_flat,
  output logic [NUM_AXES*RATE_W-1:0]   angle_err_flat,
  output logic [NUM_AXES-1:0]          sat_flags,
  output logic                         active_signal,
  output logic                         complete_signal
);
  localparam int ERR_W  = RATE_W + 2;
  localparam int PROD_W = RATE_W + SCALE_W;
  localparam int AX_W   = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
  localparam logic signed [RATE_W-1:0] RATE_MAX = {1'b0, {(RATE_W-1){1'b1}}};
  localparam logic signed [RATE_W-1:0] RATE_MIN = {1'b1, {(RATE_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_ERR, S_SCALE, S_LIMIT, S_DONE} state_t;

  state_t                      state_q;
  logic [AX_W-1:0]             axis_q;
  logic                        pending_q;

  logic        [REC_W-1:0]     tgt_q   [NUM_AXES];
  logic signed [RATE_W-1:0]    act_q   [NUM_AXES];
  logic        [NUM_AXES-1:0]  add_q;
  logic signed [SCALE_W-1:0]   mult_q  [NUM_AXES];
  logic        [SHIFT_W-1:0]   shift_q [NUM_AXES];
  logic signed [RATE_W-1:0]    lim_q   [NUM_AXES];
  logic        [RATE_W-1:0]    slew_q;

  logic signed [RATE_W-1:0]    err_q;
  logic signed [RATE_W-1:0]    p_q;
  logic signed [RATE_W-1:0]    prev_q  [NUM_AXES];
  logic [NUM_AXES*RATE_W-1:0]  shadow_rate_q, shadow_err_q, rate_out_q, angle_err_q;
  logic [NUM_AXES-1:0]         shadow_sat_q, sat_q;
  logic                        active_q, complete_q;

  logic signed [ERR_W-1:0]     tgt_ext, act_ext, err_wide;
  logic signed [RATE_W-1:0]    err_d;
  logic signed [PROD_W-1:0]    prod, prod_sh;
  logic signed [RATE_W-1:0]    p_d;

  always_comb begin
    tgt_ext  = signed'({{(ERR_W-REC_W){1'b0}}, tgt_q[axis_q]}) << TGT_SHIFT;
    act_ext  = {{2{act_q[axis_q][RATE_W-1]}}, act_q[axis_q]};
    err_wide = add_q[axis_q] ? (tgt_ext - ERR_W'(CENTER) + act_ext)
                             : (tgt_ext - ERR_W'(CENTER) - act_ext);
    if (err_wide[ERR_W-1:RATE_W-1] == '0 || err_wide[ERR_W-1:RATE_W-1] == '1)
      err_d = err_wide[RATE_W-1:0];
    else
      err_d = err_wide[ERR_W-1] ? RATE_MIN : RATE_MAX;

    // Shared multiplier: only ever fed the axis currently in SCALE
    prod    = $signed({{SCALE_W{err_q[RATE_W-1]}}, err_q})
            * $signed({{RATE_W{mult_q[axis_q][SCALE_W-1]}}, mult_q[axis_q]});
    prod_sh = prod >>> shift_q[axis_q];
    if (prod_sh[PROD_W-1:RATE_W-1] == '0 || prod_sh[PROD_W-1:RATE_W-1] == '1)
      p_d = prod_sh[RATE_W-1:0];
    else
      p_d = prod_sh[PROD_W-1] ? RATE_MIN : RATE_MAX;
  end

  logic signed [RATE_W:0]      lim_abs, p_ext, lim_clamped;
  logic signed [RATE_W+1:0]    prev_ext, diff, slew_ext, slewed;
  logic        [RATE_W+1:0]    diff_abs;
  logic                        lim_hit, slew_hit;
  logic signed [RATE_W-1:0]    limit_d;

  always_comb begin
    // One extra bit lets |most-negative limit| be represented exactly
    lim_abs = {lim_q[axis_q][RATE_W-1], lim_q[axis_q]};
    if (lim_q[axis_q][RATE_W-1])
      lim_abs = -lim_abs;
    p_ext       = {p_q[RATE_W-1], p_q};
    lim_clamped = p_ext;
    lim_hit     = 1'b0;
    if (p_ext > lim_abs) begin
      lim_clamped = lim_abs;
      lim_hit     = 1'b1;
    end else if (p_ext < -lim_abs) begin
      lim_clamped = -lim_abs;
      lim_hit     = 1'b1;
    end
    prev_ext = {{2{prev_q[axis_q][RATE_W-1]}}, prev_q[axis_q]};
    diff     = {lim_clamped[RATE_W], lim_clamped} - prev_ext;
    diff_abs = diff[RATE_W+1] ? -diff : diff;
    slew_ext = {2'b00, slew_q};
    slewed   = prev_ext + (diff[RATE_W+1] ? -slew_ext : slew_ext);
    slew_hit = (slew_q != '0) && (diff_abs > {2'b00, slew_q});
    limit_d  = slew_hit ? slewed[RATE_W-1:0] : lim_clamped[RATE_W-1:0];
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      axis_q        <= '0;
      pending_q     <= 1'b0;
      add_q         <= '0;
      slew_q        <= '0;
      err_q         <= '0;
      p_q           <= '0;
      shadow_rate_q <= '0;
      shadow_err_q  <= '0;
      shadow_sat_q  <= '0;
      rate_out_q    <= '0;
      angle_err_q   <= '0;
      sat_q         <= '0;
      active_q      <= 1'b0;
      complete_q    <= 1'b0;
      for (int i = 0; i < NUM_AXES; i++) begin
        tgt_q[i]   <= '0;
        act_q[i]   <= '0;
        mult_q[i]  <= '0;
        shift_q[i] <= '0;
        lim_q[i]   <= '0;
        prev_q[i]  <= '0;
      end
    end else begin
      active_q   <= (state_q == S_LATCH) || (state_q == S_ERR) ||
                    (state_q == S_SCALE) || (state_q == S_LIMIT);
      complete_q <= (state_q == S_DONE);
      if (start_signal && state_q != S_IDLE && state_q != S_DONE)
        pending_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start_signal)
            state_q <= S_LATCH;
        end
        S_LATCH: begin
          for (int i = 0; i < NUM_AXES; i++) begin
            tgt_q[i]   <= target_flat[i*REC_W +: REC_W];
            act_q[i]   <= actual_flat[i*RATE_W +: RATE_W];
            mult_q[i]  <= scale_mult_flat[i*SCALE_W +: SCALE_W];
            shift_q[i] <= scale_shift_flat[i*SHIFT_W +: SHIFT_W];
            lim_q[i]   <= rate_limit_flat[i*RATE_W +: RATE_W];
          end
          add_q   <= actual_add;
          slew_q  <= slew_limit;
          axis_q  <= '0;
          state_q <= S_ERR;
        end
        S_ERR: begin
          err_q   <= err_d;
          state_q <= S_SCALE;
        end
        S_SCALE: begin
          p_q     <= p_d;
          state_q <= S_LIMIT;
        end
        S_LIMIT: begin
          shadow_rate_q[axis_q*RATE_W +: RATE_W] <= limit_d;
          shadow_err_q[axis_q*RATE_W +: RATE_W]  <= err_q;
          shadow_sat_q[axis_q]                   <= lim_hit | slew_hit;
          prev_q[axis_q]                         <= limit_d;
          if (axis_q == AX_W'(NUM_AXES-1)) begin
            state_q <= S_DONE;
          end else begin
            axis_q  <= axis_q + 1'b1;
            state_q <= S_ERR;
          end
        end
        S_DONE: begin
          rate_out_q  <= shadow_rate_q;
          angle_err_q <= shadow_err_q;
          sat_q       <= shadow_sat_q;
          if (pending_q || start_signal) begin
            pending_q <= 1'b0;
            state_q   <= S_LATCH;
          end else begin
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rate_out_flat   = rate_out_q;
  assign angle_err_flat  = angle_err_q;
  assign sat_flags       = sat_q;
  assign active_signal   = active_q;
  assign complete_signal = complete_q;
endmodule

// File: tb/tb_multi_axis_angle_ctrl.sv
// tb/tb_multi_axis_angle_ctrl.sv - scoreboard bench for multi_axis_angle_ctrl
module tb_multi_axis_angle_ctrl;
  localparam int NA = 3, REC = 8, RW = 16, SW = 16, SHW = 5;

  logic                 us_clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 start_signal = 1'b0;
  logic [NA*REC-1:0]    target_flat = '0;
  logic [NA*RW-1:0]     actual_flat = '0;
  logic [NA-1:0]        actual_add = '0;
  logic [NA*SW-1:0]     scale_mult_flat = '0;
  logic [NA*SHW-1:0]    scale_shift_flat = '0;
  logic [NA*RW-1:0]     rate_limit_flat = '0;
  logic [RW-1:0]        slew_limit = '0;
  logic [NA*RW-1:0]     rate_out_flat, angle_err_flat;
  logic [NA-1:0]        sat_flags;
  logic                 active_signal, complete_signal;

  multi_axis_angle_ctrl dut (
    .us_clk(us_clk), .resetn(resetn), .start_signal(start_signal),
    .target_flat(target_flat), .actual_flat(actual_flat), .actual_add(actual_add),
    .scale_mult_flat(scale_mult_flat), .scale_shift_flat(scale_shift_flat),
    .rate_limit_flat(rate_limit_flat), .slew_limit(slew_limit),
    .rate_out_flat(rate_out_flat), .angle_err_flat(angle_err_flat), .sat_flags(sat_flags),
    .active_signal(active_signal), .complete_signal(complete_signal)
  );

  always #5 us_clk = ~us_clk;

  typedef struct {
    logic [NA*RW-1:0] rate;
    logic [NA*RW-1:0] err;
    logic [NA-1:0]    sat;
  } exp_t;

  exp_t exp_q[$];
  int   prev_m [NA];
  int   n_checks = 0, n_fail = 0, n_complete = 0, cyc = 0;

  always @(posedge us_clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: rules applied directly with integer arithmetic on the current inputs
  task automatic model_push();
    exp_t x;
    for (int i = 0; i < NA; i++) begin
      longint e, p;
      int lim, c, slew, step;
      bit s;
      e = longint'(target_flat[i*REC +: REC]) * 4 - 500;
      if (actual_add[i]) e = e + $signed(actual_flat[i*RW +: RW]);
      else               e = e - $signed(actual_flat[i*RW +: RW]);
      e = sat16(e);
      p = sat16((e * longint'($signed(scale_mult_flat[i*SW +: SW]))) >>> scale_shift_flat[i*SHW +: SHW]);
      lim = $signed(rate_limit_flat[i*RW +: RW]);
      if (lim < 0) lim = -lim;
      c = int'(p);
      s = 1'b0;
      if (c > lim) begin c = lim; s = 1'b1; end
      else if (c < -lim) begin c = -lim; s = 1'b1; end
      slew = int'(slew_limit);
      step = (c > prev_m[i]) ? c - prev_m[i] : prev_m[i] - c;
      if (slew != 0 && step > slew) begin
        c = (c > prev_m[i]) ? prev_m[i] + slew : prev_m[i] - slew;
        s = 1'b1;
      end
      prev_m[i] = c;
      x.rate[i*RW +: RW] = RW'(c);
      x.err[i*RW +: RW]  = RW'(e);
      x.sat[i]           = s;
    end
    exp_q.push_back(x);
  endtask

  // Monitor: every completion consumes the oldest expectation
  always @(negedge us_clk) begin
    if (complete_signal) begin
      exp_t x;
      n_complete++;
      check("active_during_complete", active_signal, 0);
      check("complete_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("rate_out_flat", rate_out_flat, x.rate);
        check("angle_err_flat", angle_err_flat, x.err);
        check("sat_flags", sat_flags, x.sat);
      end
    end
  end

  task automatic set_all(input int tgt, input int act, input bit add, input int mult,
                         input int shift, input int lim, input int slew);
    for (int i = 0; i < NA; i++) begin
      target_flat[i*REC +: REC]       = REC'(tgt);
      actual_flat[i*RW +: RW]         = RW'(act);
      actual_add[i]                   = add;
      scale_mult_flat[i*SW +: SW]     = SW'(mult);
      scale_shift_flat[i*SHW +: SHW]  = SHW'(shift);
      rate_limit_flat[i*RW +: RW]     = RW'(lim);
    end
    slew_limit = RW'(slew);
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < NA; i++) begin
      target_flat[i*REC +: REC]      = REC'($urandom_range(0, 255));
      actual_flat[i*RW +: RW]        = ($urandom_range(0, 3) == 0) ? RW'($urandom)
                                       : RW'($urandom_range(0, 4000)) - 16'd2000;
      actual_add[i]                  = 1'($urandom_range(0, 1));
      scale_mult_flat[i*SW +: SW]    = SW'($urandom_range(0, 600)) - 16'd300;
      scale_shift_flat[i*SHW +: SHW] = SHW'($urandom_range(0, 8));
      rate_limit_flat[i*RW +: RW]    = RW'($urandom_range(0, 20000));
    end
    slew_limit = ($urandom_range(0, 1) == 1) ? RW'($urandom_range(1, 400)) : '0;
  endtask

  task automatic wait_complete(input int base, input int want, input string name);
    bit got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge us_clk);
      if (complete_signal) got = 1'b1;
    end
    check({name, "_done"}, got, 1);
    if (got) check({name, "_latency"}, cyc - base, want);
  endtask

  task automatic run_once(input bit scramble, input string name);
    int base;
    @(posedge us_clk); #1;
    model_push();
    start_signal = 1'b1;
    @(posedge us_clk); #1;
    base = cyc;
    start_signal = 1'b0;
    if (scramble) begin
      @(posedge us_clk); #1;
      randomize_inputs();
    end
    wait_complete(base, 2 + 3*NA, name);
  endtask

  task automatic do_reset();
    @(posedge us_clk); #1;
    resetn = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NA; i++) prev_m[i] = 0;
    repeat (2) @(posedge us_clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, cnt;
    int slew_exp [4] = '{32, 64, 96, 100};
    int sat_exp  [4] = '{1, 1, 1, 0};
    for (int i = 0; i < NA; i++) prev_m[i] = 0;
    repeat (3) @(posedge us_clk);
    @(negedge us_clk);
    check("reset_rate_out", rate_out_flat, 0);
    check("reset_angle_err", angle_err_flat, 0);
    check("reset_sat", sat_flags, 0);
    check("reset_active", active_signal, 0);
    check("reset_complete", complete_signal, 0);
    #1 resetn = 1'b1;

    set_all(125, 0, 0, 1, 0, 1600, 0);
    run_once(0, "centre");
    check("centre_rate0", $signed(rate_out_flat[RW-1:0]), 0);

    set_all(150, 32, 0, 1, 0, 1600, 0);
    run_once(0, "linear_sub");
    check("linear_sub_err0", $signed(angle_err_flat[RW-1:0]), 68);
    check("linear_sub_rate2", $signed(rate_out_flat[2*RW +: RW]), 68);
    set_all(150, 32, 1, 1, 0, 1600, 0);
    run_once(0, "linear_add");
    check("linear_add_rate1", $signed(rate_out_flat[RW +: RW]), 132);

    set_all(255, 0, 0, 64, 0, 1600, 0);
    run_once(0, "clamp_hi");
    check("clamp_hi_rate0", $signed(rate_out_flat[RW-1:0]), 1600);
    check("clamp_hi_sat", sat_flags, 3'b111);
    set_all(0, 0, 0, 64, 0, 1600, 0);
    run_once(0, "clamp_lo");
    check("clamp_lo_rate0", $signed(rate_out_flat[RW-1:0]), -1600);

    do_reset();
    set_all(150, 0, 0, 1, 0, 1600, 32);
    for (int r = 0; r < 4; r++) begin
      run_once(0, "slew");
      check("slew_rate0", $signed(rate_out_flat[RW-1:0]), slew_exp[r]);
      check("slew_sat0", sat_flags[0], sat_exp[r]);
    end

    // Queued start: pulse while axis 1 is in SCALE
    randomize_inputs();
    @(posedge us_clk); #1;
    cnt = n_complete;
    model_push();
    model_push();
    start_signal = 1'b1;
    @(posedge us_clk); #1;
    base = cyc;
    start_signal = 1'b0;
    repeat (5) @(posedge us_clk);
    #1 start_signal = 1'b1;
    @(posedge us_clk); #1;
    start_signal = 1'b0;
    wait_complete(base, 2 + 3*NA, "queued_first");
    wait_complete(base, 2*(2 + 3*NA), "queued_second");
    repeat (30) @(posedge us_clk);
    check("queued_pulse_count", n_complete - cnt, 2);

    // Reset while axis 2 is in ERR
    randomize_inputs();
    @(posedge us_clk); #1;
    model_push();
    start_signal = 1'b1;
    @(posedge us_clk); #1;
    start_signal = 1'b0;
    repeat (7) @(posedge us_clk);
    #1 resetn = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NA; i++) prev_m[i] = 0;
    cnt = n_complete;
    @(negedge us_clk);
    check("midreset_rate_out", rate_out_flat, 0);
    check("midreset_angle_err", angle_err_flat, 0);
    check("midreset_active", active_signal, 0);
    @(posedge us_clk); #1 resetn = 1'b1;
    repeat (20) @(posedge us_clk);
    check("midreset_no_complete", n_complete - cnt, 0);
    randomize_inputs();
    run_once(0, "post_reset");

    for (int r = 0; r < 30; r++) begin
      if (r == 0) randomize_inputs();
      run_once(1, "random");
    end

    repeat (5) @(posedge us_clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
